// File: rtl/li_fifo_arbiter.sv
// Round-robin ready-latency write arbiter sharing one shell FIFO among NUM_REQ requesters.
// Define LI_FIFO_ARB_PROTOCOL_CHECK_EN to build the sticky stray-valid checker behind o_error.
module li_fifo_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int READY_LATENCY = 2,
    parameter int MAX_BURST     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ready,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic                          o_fifo_enq,
    input  logic                          i_fifo_almost_full,
    output logic                          o_error
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int SW   = IDXW + 1;
    localparam int BCW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int RL   = READY_LATENCY;

    logic [IDXW-1:0]       r_ptr;
    logic [BCW-1:0]        r_bcnt;
    logic [IDXW-1:0]       r_last;
    logic                  r_last_vld;
    logic [NUM_REQ-1:0]    r_ready;
    logic [RL:0]           r_pipe_live;
    logic [RL:0][IDXW-1:0] r_pipe_idx;
    logic                  r_fifo_enq;
    logic [DATA_WIDTH-1:0] r_fifo_data;

    logic                  w_found;
    logic                  w_grant;
    logic [SW-1:0]         w_sum;
    logic [IDXW-1:0]       w_gidx;
    logic [IDXW-1:0]       w_gidx_inc;
    logic [BCW-1:0]        w_bcnt_new;
    logic                  w_burst_done;
    logic                  w_slot_live;
    logic [IDXW-1:0]       w_slot_idx;
    logic                  w_slot_hit;
    logic [DATA_WIDTH-1:0] w_slot_data;

    // First requester at or after the priority pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(NUM_REQ))
                w_sum = w_sum - SW'(NUM_REQ);
            if (!w_found && i_req[w_sum[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IDXW-1:0];
            end
        end
    end

    assign w_grant      = w_found && !i_fifo_almost_full;
    assign w_gidx_inc   = (w_gidx == IDXW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_bcnt_new   = (r_last_vld && (r_last == w_gidx)) ? r_bcnt + 1'b1 : '0;
    assign w_burst_done = (MAX_BURST == 1) || (w_bcnt_new == BCW'(MAX_BURST - 1));

    assign w_slot_live  = r_pipe_live[RL];
    assign w_slot_idx   = r_pipe_idx[RL];
    assign w_slot_hit   = w_slot_live && i_valid[w_slot_idx];

    always_comb begin
        w_slot_data = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_slot_idx == IDXW'(n))
                w_slot_data = i_data[n*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage 0 loads alongside o_ready, so stage RL lines up with the requester's valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_bcnt      <= '0;
            r_last      <= '0;
            r_last_vld  <= 1'b0;
            r_ready     <= '0;
            r_pipe_live <= '0;
            r_pipe_idx  <= '0;
            r_fifo_enq  <= 1'b0;
            r_fifo_data <= '0;
        end else begin
            r_ready    <= w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
            r_last_vld <= w_grant;
            if (w_grant) begin
                r_last <= w_gidx;
                if (w_burst_done) begin
                    r_ptr  <= w_gidx_inc;
                    r_bcnt <= '0;
                end else begin
                    r_ptr  <= w_gidx;
                    r_bcnt <= w_bcnt_new;
                end
            end
            r_pipe_live <= {r_pipe_live[RL-1:0], w_grant};
            r_pipe_idx  <= {r_pipe_idx[RL-1:0], w_gidx};
            r_fifo_enq  <= w_slot_hit;
            if (w_slot_hit)
                r_fifo_data <= w_slot_data;
        end
    end

    assign o_ready     = r_ready;
    assign o_fifo_enq  = r_fifo_enq;
    assign o_fifo_data = r_fifo_data;

`ifdef LI_FIFO_ARB_PROTOCOL_CHECK_EN
    localparam int MW = $clog2(RL + 2);

    logic [MW-1:0]      r_mask_cnt;
    logic               r_error;
    logic [NUM_REQ-1:0] w_expect;
    logic               w_stray;

    assign w_expect = w_slot_live ? (NUM_REQ'(1) << w_slot_idx) : '0;
    assign w_stray  = |(i_valid & ~w_expect);

    // Valids answering grants discarded by a reset may arrive for RL+1 cycles; ignore them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask_cnt <= MW'(RL + 1);
            r_error    <= 1'b0;
        end else if (r_mask_cnt != '0) begin
            r_mask_cnt <= r_mask_cnt - 1'b1;
        end else if (w_stray) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_li_fifo_arbiter.sv
// Directed bench for li_fifo_arbiter: requester model answers grants, scoreboard times each enqueue.
// Expected o_error follows LI_FIFO_ARB_PROTOCOL_CHECK_EN.
module tb_li_fifo_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    i_req;
    logic [NR-1:0]    i_valid;
    logic [NR*DW-1:0] i_data;
    logic [NR-1:0]    o_ready;
    logic [DW-1:0]    o_fifo_data;
    logic             o_fifo_enq;
    logic             i_fifo_almost_full;
    logic             o_error;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [NR-1:0] hist0, hist1;
    logic          stale0, stale1;
    logic          autoValid;
    logic [NR-1:0] honorMask, extraValid;
    logic [DW-1:0] nextData;
    logic          expError;

    int contSeq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int bpPre[4]    = '{3, 3, 0, 0};
    int bpPost[3]   = '{1, 1, 2};
    int rstSeq[3]   = '{0, 0, 1};

    li_fifo_arbiter #(
        .NUM_REQ       (NR),
        .DATA_WIDTH    (DW),
        .READY_LATENCY (2),
        .MAX_BURST     (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .i_req              (i_req),
        .i_valid            (i_valid),
        .i_data             (i_data),
        .o_ready            (o_ready),
        .o_fifo_data        (o_fifo_data),
        .o_fifo_enq         (o_fifo_enq),
        .i_fifo_almost_full (i_fifo_almost_full),
        .o_error            (o_error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: check scoreboard-timed enqueue and error, then answer grants seen two cycles ago.
    task automatic applyStimulus();
        logic [NR-1:0] vld;
        @(posedge clock);
        #1;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            checkOutput("enq", o_fifo_enq, 1);
            checkOutput("enq_data", o_fifo_data, sbq[0].data);
            void'(sbq.pop_front());
        end else begin
            checkOutput("no_enq", o_fifo_enq, 0);
        end
        checkOutput("error", o_error, expError);
        if (autoValid) begin
            vld = (hist1 & honorMask) | extraValid;
            for (int n = 0; n < NR; n++) begin
                if (hist1[n] && honorMask[n] && !stale1) begin
                    i_data[n*DW +: DW] = nextData;
                    sbq.push_back('{due: cyc + 1, data: nextData});
                    nextData = nextData + 1;
                end else begin
                    i_data[n*DW +: DW] = DW'(32'hBAD0_0000 + n);
                end
            end
            i_valid = vld;
        end
        stale1 = stale0;
        stale0 = 1'b0;
        hist1  = hist0;
        hist0  = o_ready;
    endtask

    initial begin
        reset              = 1'b1;
        i_req              = '1;
        i_valid            = '1;
        i_data             = '1;
        i_fifo_almost_full = 1'b1;
        autoValid          = 1'b0;
        honorMask          = '1;
        extraValid         = '0;
        nextData           = 32'h100;
        expError           = 1'b0;
        hist0              = '0;
        hist1              = '0;
        stale0             = 1'b0;
        stale1             = 1'b0;

        $display("[TB] reset with all inputs high");
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("reset_ready", o_ready, 0);
            checkOutput("reset_data", o_fifo_data, 0);
        end
        reset = 1'b0;
        applyStimulus();
        checkOutput("release_ready", o_ready, 0);

        $display("[TB] full contention");
        i_fifo_almost_full = 1'b0;
        i_valid            = '0;
        i_data             = '0;
        autoValid          = 1'b1;
        i_req              = '1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("contention_gnt", o_ready, NR'(1) << contSeq[i]);
        end
        i_req = '0;
        applyStimulus();
        checkOutput("contention_idle", o_ready, 0);
        repeat (2) applyStimulus();

        $display("[TB] single requester");
        nextData = 32'hA0;
        i_req    = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            checkOutput("single_gnt", o_ready, 4'b0100);
        end
        i_req = '0;
        applyStimulus();
        checkOutput("single_idle", o_ready, 0);
        repeat (2) applyStimulus();

        $display("[TB] back-pressure");
        nextData = 32'h200;
        i_req    = '1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("bp_pre_gnt", o_ready, NR'(1) << bpPre[i]);
        end
        i_fifo_almost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("bp_hold", o_ready, 0);
        end
        i_fifo_almost_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("bp_post_gnt", o_ready, NR'(1) << bpPost[i]);
        end
        i_req = '0;
        applyStimulus();
        checkOutput("bp_idle", o_ready, 0);
        repeat (2) applyStimulus();

        $display("[TB] stray valid on requester 1 in requester 3 slot");
        i_req = 4'b1000;
        applyStimulus();
        checkOutput("proto_gnt", o_ready, 4'b1000);
        i_req = '0;
        applyStimulus();
        checkOutput("proto_idle", o_ready, 0);
        honorMask  = 4'b0111;
        extraValid = 4'b0010;
        applyStimulus();
        extraValid = '0;
        honorMask  = '1;
`ifdef LI_FIFO_ARB_PROTOCOL_CHECK_EN
        expError = 1'b1;
`endif
        applyStimulus();
        checkOutput("proto_idle2", o_ready, 0);
        applyStimulus();

        $display("[TB] reset with grants in flight");
        nextData = 32'h300;
        i_req    = '1;
        applyStimulus();
        checkOutput("mid_gnt_a", o_ready, 4'b1000);
        applyStimulus();
        checkOutput("mid_gnt_b", o_ready, 4'b1000);
        reset    = 1'b1;
        stale0   = 1'b1;
        stale1   = 1'b1;
        expError = 1'b0;
        applyStimulus();
        checkOutput("mid_reset_ready", o_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("mid_after_gnt", o_ready, NR'(1) << rstSeq[i]);
        end
        i_req = '0;
        applyStimulus();
        checkOutput("mid_idle", o_ready, 0);
        repeat (3) applyStimulus();

        checkOutput("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/li_fifo_arbiter.md
# li_fifo_arbiter

Round-robin write arbiter that shares one latency-insensitive shell FIFO (the qsys_fifo single-clock wrapper) among NUM_REQ upstream requesters. It issues ready-latency grants and tracks the in-flight grants in a pipeline. It then muxes the granted requester's data into the FIFO enqueue port and stops granting while the FIFO reports almost-full. It sits between the relay stations of several producers and a shared shell input FIFO.

## Interface
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width.
- READY_LATENCY, 2, cycles from grant (o_ready) to the requester's data (i_valid); must be at least 1.
- MAX_BURST, 2, maximum number of consecutive grants to one requester before priority rotates; must be at least 1.

- clock  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  NUM_REQ  requester n has data pending.
- i_valid  in  NUM_REQ  requester n presents data, legal only READY_LATENCY cycles after its grant.
- i_data  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- o_ready  out  NUM_REQ  registered one-hot grant.
- o_fifo_data  out  DATA_WIDTH  registered data to the FIFO i_data.
- o_fifo_enq  out  1  registered, drives the FIFO i_enq.
- i_fifo_almost_full  in  1  from the FIFO o_almost_full.
- o_error  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- **Arbitration state:**
  - priority pointer ptr (0..NUM_REQ-1);
  - burst counter bcnt (0..MAX_BURST-1);
  - last-granted index.
- **Each cycle t:**
  - If i_fifo_almost_full is 0 and any i_req bit is set, pick the first requesting index g, searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - Register o_ready = one-hot(g); otherwise o_ready is 0.
- **Pointer update on a grant to g:**
  - If g equals the last-granted index, increment bcnt; otherwise set bcnt to 0.
  - If bcnt reaches MAX_BURST-1 (or MAX_BURST = 1), set ptr = g+1 modulo NUM_REQ and bcnt = 0; otherwise set ptr = g.
- **Idle cycles:** a cycle without a grant leaves ptr and bcnt unchanged, and clears last-granted so the next burst restarts.
- **Grant pipeline:**
  - A shift register, READY_LATENCY+1 stages of {live, index}, is loaded when o_ready is set.
  - The stage aligned with cycle t+READY_LATENCY of the grant is the expected slot.
- **Enqueue:**
  - If the expected slot is live and i_valid[index] is 1: the next cycle o_fifo_enq = 1 and o_fifo_data = that requester's data.
  - If the slot is live and i_valid is 0, the grant is forfeited: no enqueue, no error.
- **Stray valid:** i_valid on any index other than the live expected slot is a violation. The datum is dropped and never enqueued.
- **Requester-side almost-full:** the arbiter applies no extra back-pressure. Grants already issued always complete.

## Timing
- **Reset values:** o_ready = 0, o_fifo_enq = 0, o_fifo_data = 0, o_error = 0. Internal state clears to ptr = 0, bcnt = 0, pipeline not live.
- **Grant timing:** i_req/i_fifo_almost_full sampled in cycle t → o_ready in cycle t+1.
- **End-to-end latency:** o_ready in cycle t → i_valid in cycle t+READY_LATENCY → o_fifo_enq in cycle t+READY_LATENCY+1.
- **Throughput:** one grant and one enqueue per cycle sustained.
- **FIFO threshold sizing:** after almost-full rises in cycle t, up to READY_LATENCY+2 further writes can still land. The integrator sizes the FIFO almost-full threshold to absorb them.
- **Reset during operation:**
  - In-flight grants are discarded. Valids arriving for them in the READY_LATENCY+1 cycles after reset deasserts are dropped silently.
  - Error checking is masked during this window by a post-reset counter.
- **Simultaneous events:** i_req falling in the same cycle as its grant has no effect, and the grant stands. Almost-full and a request in the same cycle produce no grant.

## Configuration
- **Macro:** LI_FIFO_ARB_PROTOCOL_CHECK_EN.
- **Defined:** violations (stray valid) set o_error, which stays set until reset.
- **Undefined:**
  - o_error is tied to 0 and the checker logic is absent.
  - Stray valids are still dropped.

## Test plan
All scenarios use NUM_REQ = 4, READY_LATENCY = 2, MAX_BURST = 2.
- **Reset:** reset held 3 cycles with all inputs at 1 → o_ready = 0, o_fifo_enq = 0, o_error = 0 throughout and the cycle after release.
- **Single requester:** i_req = 4'b0100; requester 2 returns 0xA0, 0xA1, ... two cycles after each grant → o_ready = 4'b0100 every cycle; enqueue order 0xA0, 0xA1, ..., each 3 cycles after its grant.
- **Full contention:** i_req = 4'b1111 with all valids honoured → grant sequence 0,0,1,1,2,2,3,3,0,0.
- **Back-pressure:** i_fifo_almost_full = 1 for cycles 10..14 → no o_ready in cycles 11..15; the grants from cycles 9 and 10 still enqueue in cycles 12 and 13.
- **Protocol check:** grant to requester 3; i_valid[1] = 1 in the aligned cycle →
  - no enqueue of requester 1's data;
  - o_error = 1 next cycle and stays set (0 when the macro is undefined);
  - requester 3 forfeits the grant.
- **Mid-operation reset:** reset pulsed 1 cycle with two grants in flight; the old valids arrive afterwards → no o_fifo_enq, o_error = 0, next grant goes to index 0 first.
